// File: rtl/armv4_bus_responder.sv
// armv4_bus_responder: byte-addressed little-endian memory serving the armv4core
// rom (instruction) and ram (data) buses, plus a small MMIO window holding a
// console TX register, a reload timer and the interrupt source for the core.

`ifndef MEM_B
`define MEM_B 2'b00
`endif
`ifndef MEM_H
`define MEM_H 2'b01
`endif
`ifndef MEM_W
`define MEM_W 2'b10
`endif

module armv4_bus_responder #(
    parameter int unsigned MEM_BYTES = 65536,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_rom_en,
    input  logic [31:0] i_rom_addr,
    output logic [31:0] o_rom_data,
    input  logic        i_ram_en,
    input  logic        i_ram_wr,
    input  logic [1:0]  i_ram_size,
    input  logic [31:0] i_ram_addr,
    input  logic [31:0] i_ram_wdata,
    output logic [31:0] o_ram_rdata,
    output logic        o_irq,
    output logic [31:0] o_irq_r0,
    output logic [31:0] o_irq_r1,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_err
);

    localparam int unsigned AW = $clog2(MEM_BYTES);

    localparam logic [5:0] OFF_TX   = 6'h00;
    localparam logic [5:0] OFF_LOAD = 6'h04;
    localparam logic [5:0] OFF_CNT  = 6'h08;
    localparam logic [5:0] OFF_R0   = 6'h0C;
    localparam logic [5:0] OFF_R1   = 6'h10;
    localparam logic [5:0] OFF_CTRL = 6'h14;

    logic [7:0]    mem [MEM_BYTES];

    logic [AW-1:0] rom_idx [4];
    logic [AW-1:0] ram_idx [4];
    logic [31:0]   rom_word;
    logic [31:0]   ram_word;
    logic [3:0]    byte_en;

    logic          is_word;
    logic          mmio_hit;
    logic          mmio_acc;
    logic          mmio_wr;
    logic          mem_wr;
    logic [5:0]    mmio_off;
    logic          off_valid;
    logic          bad_access;
    logic [31:0]   mmio_rdata;

    logic          wr_tx;
    logic          wr_load;
    logic          wr_r0;
    logic          wr_r1;
    logic          wr_ctrl;
    logic          timer_expire;
    logic          set_evt;
    logic          clr_evt;

    logic [31:0]   load_q;
    logic [31:0]   cnt_q;
    logic [31:0]   r0_q;
    logic [31:0]   r1_q;
    logic          en_q;
    logic          pend_q;

    // Upper address bits beyond the memory size only matter for MMIO decode.
    logic          unused_rom_bits;
    assign unused_rom_bits = ^i_rom_addr[31:AW];

    // Byte indices for both ports; each byte wraps modulo the memory size.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rom_idx[k] = i_rom_addr[AW-1:0] + AW'(k);
            ram_idx[k] = i_ram_addr[AW-1:0] + AW'(k);
        end
        rom_word = {mem[rom_idx[3]], mem[rom_idx[2]], mem[rom_idx[1]], mem[rom_idx[0]]};
        ram_word = {mem[ram_idx[3]], mem[ram_idx[2]], mem[ram_idx[1]], mem[ram_idx[0]]};
    end

    // Decode the ram access into memory vs MMIO and classify MMIO writes.
    always_comb begin
        is_word  = (i_ram_size != `MEM_B) && (i_ram_size != `MEM_H);
        mmio_hit = (i_ram_addr[31:6] == MMIO_BASE[31:6]);
        mmio_acc = i_ram_en && mmio_hit;
        mmio_wr  = mmio_acc && i_ram_wr && is_word;
        mem_wr   = i_ram_en && i_ram_wr && !mmio_hit;
        mmio_off = i_ram_addr[5:0];

        byte_en[0] = 1'b1;
        byte_en[1] = (i_ram_size != `MEM_B);
        byte_en[2] = is_word;
        byte_en[3] = is_word;

        off_valid = (mmio_off == OFF_TX)  || (mmio_off == OFF_LOAD) ||
                    (mmio_off == OFF_CNT) || (mmio_off == OFF_R0)   ||
                    (mmio_off == OFF_R1)  || (mmio_off == OFF_CTRL);
        bad_access = mmio_acc && (!is_word || !off_valid);

        wr_tx   = mmio_wr && (mmio_off == OFF_TX);
        wr_load = mmio_wr && (mmio_off == OFF_LOAD);
        wr_r0   = mmio_wr && (mmio_off == OFF_R0);
        wr_r1   = mmio_wr && (mmio_off == OFF_R1);
        wr_ctrl = mmio_wr && (mmio_off == OFF_CTRL);

        // A LOAD write in the same cycle as expiry suppresses the event.
        timer_expire = (load_q != 32'd0) && (cnt_q == 32'd1) && !wr_load;
        set_evt      = timer_expire || (wr_ctrl && i_ram_wdata[2]);
        clr_evt      = wr_ctrl && i_ram_wdata[1];
    end

    // MMIO read mux; write-only and unmapped offsets read as zero.
    always_comb begin
        mmio_rdata = 32'd0;
        case (mmio_off)
            OFF_LOAD: mmio_rdata = load_q;
            OFF_CNT:  mmio_rdata = cnt_q;
            OFF_R0:   mmio_rdata = r0_q;
            OFF_R1:   mmio_rdata = r1_q;
            OFF_CTRL: mmio_rdata = {29'd0, 1'b0, pend_q, en_q};
            default:  mmio_rdata = 32'd0;
        endcase
    end

    // Memory array writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[ram_idx[k]] <= i_ram_wdata[8*k +: 8];
                end
            end
        end
    end

    // Registered rom and ram read data; the rom sees pre-write contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rom_data  <= 32'd0;
            o_ram_rdata <= 32'd0;
        end else begin
            if (i_rom_en) begin
                o_rom_data <= rom_word;
            end
            if (i_ram_en && !i_ram_wr) begin
                if (mmio_hit) begin
                    o_ram_rdata <= is_word ? mmio_rdata : 32'd0;
                end else if (i_ram_size == `MEM_B) begin
                    o_ram_rdata <= {24'd0, ram_word[7:0]};
                end else if (i_ram_size == `MEM_H) begin
                    o_ram_rdata <= {16'd0, ram_word[15:0]};
                end else begin
                    o_ram_rdata <= ram_word;
                end
            end
        end
    end

    // Reload timer: counts down while LOAD is nonzero, reloading on 1 or 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q <= 32'd0;
            cnt_q  <= 32'd0;
        end else if (wr_load) begin
            load_q <= i_ram_wdata;
            cnt_q  <= i_ram_wdata;
        end else if (load_q != 32'd0) begin
            if (cnt_q <= 32'd1) begin
                cnt_q <= load_q;
            end else begin
                cnt_q <= cnt_q - 32'd1;
            end
        end
    end

    // Interrupt argument registers and control enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_q <= 32'd0;
            r1_q <= 32'd0;
            en_q <= 1'b0;
        end else begin
            if (wr_r0) begin
                r0_q <= i_ram_wdata;
            end
            if (wr_r1) begin
                r1_q <= i_ram_wdata;
            end
            if (wr_ctrl) begin
                en_q <= i_ram_wdata[0];
            end
        end
    end

    // Pending flag with set-over-clear priority, argument snapshot and irq output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= 1'b0;
            o_irq    <= 1'b0;
            o_irq_r0 <= 32'd0;
            o_irq_r1 <= 32'd0;
        end else begin
            if (set_evt) begin
                pend_q   <= 1'b1;
                o_irq_r0 <= r0_q;
                o_irq_r1 <= r1_q;
            end else if (clr_evt) begin
                pend_q <= 1'b0;
            end
            o_irq <= pend_q && en_q;
        end
    end

    // Single-cycle console and error strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_tx_valid <= 1'b0;
            o_tx_data  <= 8'd0;
            o_err      <= 1'b0;
        end else begin
            o_tx_valid <= wr_tx;
            if (wr_tx) begin
                o_tx_data <= i_ram_wdata[7:0];
            end
            o_err <= bad_access;
        end
    end

endmodule

// File: tb/tb_armv4_bus_responder.sv
// tb_armv4_bus_responder: directed checks of memory ports, MMIO registers,
// timer interrupt timing and asynchronous reset.

`ifndef MEM_B
`define MEM_B 2'b00
`endif
`ifndef MEM_H
`define MEM_H 2'b01
`endif
`ifndef MEM_W
`define MEM_W 2'b10
`endif

module tb_armv4_bus_responder;

    logic        clk;
    logic        rst_n;
    logic        i_rom_en;
    logic [31:0] i_rom_addr;
    logic [31:0] o_rom_data;
    logic        i_ram_en;
    logic        i_ram_wr;
    logic [1:0]  i_ram_size;
    logic [31:0] i_ram_addr;
    logic [31:0] i_ram_wdata;
    logic [31:0] o_ram_rdata;
    logic        o_irq;
    logic [31:0] o_irq_r0;
    logic [31:0] o_irq_r1;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        o_err;

    int compared;
    int mismatched;

    localparam logic [31:0] MMIO = 32'hFFFF_0000;

    armv4_bus_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rom_en    (i_rom_en),
        .i_rom_addr  (i_rom_addr),
        .o_rom_data  (o_rom_data),
        .i_ram_en    (i_ram_en),
        .i_ram_wr    (i_ram_wr),
        .i_ram_size  (i_ram_size),
        .i_ram_addr  (i_ram_addr),
        .i_ram_wdata (i_ram_wdata),
        .o_ram_rdata (o_ram_rdata),
        .o_irq       (o_irq),
        .o_irq_r0    (o_irq_r0),
        .o_irq_r1    (o_irq_r1),
        .o_tx_valid  (o_tx_valid),
        .o_tx_data   (o_tx_data),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one ram-port cycle, then release the request.
    task automatic applyStimulus(input logic wr, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        i_ram_en    = 1'b1;
        i_ram_wr    = wr;
        i_ram_size  = size;
        i_ram_addr  = addr;
        i_ram_wdata = wdata;
        tick();
        i_ram_en    = 1'b0;
        i_ram_wr    = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
        end
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        rst_n       = 1'b0;
        i_rom_en    = 1'b0;
        i_rom_addr  = 32'd0;
        i_ram_en    = 1'b0;
        i_ram_wr    = 1'b0;
        i_ram_size  = `MEM_W;
        i_ram_addr  = 32'd0;
        i_ram_wdata = 32'd0;

        tick();
        tick();
        checkOutput("reset_rom_data", o_rom_data, 32'd0);
        checkOutput("reset_ram_rdata", o_ram_rdata, 32'd0);
        checkOutput("reset_irq", {31'd0, o_irq}, 32'd0);
        checkOutput("reset_irq_r0", o_irq_r0, 32'd0);
        checkOutput("reset_irq_r1", o_irq_r1, 32'd0);
        checkOutput("reset_tx_valid", {31'd0, o_tx_valid}, 32'd0);
        checkOutput("reset_err", {31'd0, o_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Rom read of bytes 01 23 45 67 loaded through the ram port.
        applyStimulus(1'b1, `MEM_B, 32'h0, 32'h01);
        applyStimulus(1'b1, `MEM_B, 32'h1, 32'h23);
        applyStimulus(1'b1, `MEM_B, 32'h2, 32'h45);
        applyStimulus(1'b1, `MEM_B, 32'h3, 32'h67);
        i_rom_en   = 1'b1;
        i_rom_addr = 32'h0;
        tick();
        checkOutput("rom_read_word", o_rom_data, 32'h6745_2301);
        i_rom_en   = 1'b0;
        i_rom_addr = 32'h200;
        tick();
        checkOutput("rom_hold", o_rom_data, 32'h6745_2301);

        // Ram sizes: memory holds DD CC BB AA at 0x100..0x103.
        applyStimulus(1'b1, `MEM_W, 32'h100, 32'hAABB_CCDD);
        applyStimulus(1'b0, `MEM_B, 32'h102, 32'h0);
        checkOutput("ram_read_b", o_ram_rdata, 32'h0000_00BB);
        applyStimulus(1'b0, `MEM_H, 32'h101, 32'h0);
        checkOutput("ram_read_h_unaligned", o_ram_rdata, 32'h0000_BBCC);
        applyStimulus(1'b1, `MEM_H, 32'h100, 32'hFFFF_1234);
        checkOutput("ram_rdata_hold_on_write", o_ram_rdata, 32'h0000_BBCC);
        applyStimulus(1'b0, `MEM_W, 32'h100, 32'h0);
        checkOutput("ram_read_w_after_h", o_ram_rdata, 32'hAABB_1234);

        // Wrap: word write at the top of memory spills into byte 0.
        applyStimulus(1'b1, `MEM_W, 32'h0000_FFFE, 32'h7766_5544);
        applyStimulus(1'b0, `MEM_W, 32'h0000_FFFE, 32'h0);
        checkOutput("ram_wrap_read", o_ram_rdata, 32'h7766_5544);
        applyStimulus(1'b0, `MEM_B, 32'h0, 32'h0);
        checkOutput("ram_wrap_byte0", o_ram_rdata, 32'h0000_0066);

        // Same-cycle rom read and ram write: read-before-write.
        applyStimulus(1'b1, `MEM_W, 32'h200, 32'h0);
        i_rom_en   = 1'b1;
        i_rom_addr = 32'h200;
        applyStimulus(1'b1, `MEM_W, 32'h200, 32'h1111_1111);
        checkOutput("rom_read_before_write", o_rom_data, 32'h0);
        tick();
        checkOutput("rom_reread", o_rom_data, 32'h1111_1111);
        i_rom_en = 1'b0;

        // Console TX and illegal MMIO accesses.
        applyStimulus(1'b1, `MEM_W, MMIO + 32'h00, 32'h0000_0041);
        checkOutput("tx_valid_pulse", {31'd0, o_tx_valid}, 32'd1);
        checkOutput("tx_data", {24'd0, o_tx_data}, 32'h41);
        checkOutput("tx_no_err", {31'd0, o_err}, 32'd0);
        tick();
        checkOutput("tx_valid_drop", {31'd0, o_tx_valid}, 32'd0);
        applyStimulus(1'b1, `MEM_B, MMIO + 32'h00, 32'h0000_0042);
        checkOutput("tx_byte_ignored", {31'd0, o_tx_valid}, 32'd0);
        checkOutput("err_byte_mmio", {31'd0, o_err}, 32'd1);
        tick();
        checkOutput("err_drop", {31'd0, o_err}, 32'd0);
        applyStimulus(1'b0, `MEM_W, MMIO + 32'h20, 32'h0);
        checkOutput("bad_offset_read", o_ram_rdata, 32'h0);
        checkOutput("err_bad_offset", {31'd0, o_err}, 32'd1);

        // Park a nonzero value in the ram read register for the reset check.
        applyStimulus(1'b0, `MEM_W, 32'h100, 32'h0);
        checkOutput("ram_read_before_timer", o_ram_rdata, 32'hAABB_1234);

        // Timer interrupt: LOAD=5 expires on the 5th edge after the write.
        applyStimulus(1'b1, `MEM_W, MMIO + 32'h0C, 32'h0123_4567);
        applyStimulus(1'b1, `MEM_W, MMIO + 32'h10, 32'h89AB_CDEF);
        applyStimulus(1'b1, `MEM_W, MMIO + 32'h14, 32'h1);
        applyStimulus(1'b1, `MEM_W, MMIO + 32'h04, 32'd5);
        checkOutput("irq_idle_after_load", {31'd0, o_irq}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("irq_not_yet", {31'd0, o_irq}, 32'd0);
        checkOutput("snapshot_not_yet", o_irq_r0, 32'd0);
        tick();
        checkOutput("snapshot_r0_at_pend", o_irq_r0, 32'h0123_4567);
        checkOutput("irq_lags_pend", {31'd0, o_irq}, 32'd0);
        tick();
        checkOutput("irq_rise", {31'd0, o_irq}, 32'd1);
        checkOutput("irq_r0", o_irq_r0, 32'h0123_4567);
        checkOutput("irq_r1", o_irq_r1, 32'h89AB_CDEF);
        applyStimulus(1'b1, `MEM_W, MMIO + 32'h0C, 32'h0);
        checkOutput("irq_r0_stable", o_irq_r0, 32'h0123_4567);
        applyStimulus(1'b1, `MEM_W, MMIO + 32'h14, 32'h3);
        checkOutput("irq_still_high_on_clear", {31'd0, o_irq}, 32'd1);
        tick();
        checkOutput("irq_cleared", {31'd0, o_irq}, 32'd0);
        checkOutput("irq_r0_before_second", o_irq_r0, 32'h0123_4567);
        tick();
        checkOutput("second_event_snapshot", o_irq_r0, 32'h0);
        checkOutput("second_event_r1", o_irq_r1, 32'h89AB_CDEF);
        tick();
        checkOutput("second_irq_rise", {31'd0, o_irq}, 32'd1);

        // Asynchronous reset mid-cycle while the timer runs and irq is high.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_irq", {31'd0, o_irq}, 32'd0);
        checkOutput("async_reset_ram_rdata", o_ram_rdata, 32'd0);
        checkOutput("async_reset_rom_data", o_rom_data, 32'd0);
        checkOutput("async_reset_irq_r1", o_irq_r1, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(1'b0, `MEM_W, MMIO + 32'h08, 32'h0);
        checkOutput("cnt_after_reset", o_ram_rdata, 32'd0);
        for (int i = 0; i < 8; i++) tick();
        checkOutput("no_irq_after_reset", {31'd0, o_irq}, 32'd0);
        applyStimulus(1'b0, `MEM_W, MMIO + 32'h14, 32'h0);
        checkOutput("ctrl_after_reset", o_ram_rdata, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
